// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the PWM ramp controller.
// Holds the default bank geometry, the update-engine state encoding and the
// layout of the per-channel snapshot the engine works on.
package pwm_ramp_pkg;

  localparam int NCH_D  = 8;   // PWM channels
  localparam int CW_D   = 28;  // counter / period / duty width
  localparam int DIVW_D = 8;   // ramp divider width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UPDATE = 2'd2
  } upd_state_t;

  // One channel's pending + active state, as captured by the engine in LOAD.
  typedef struct packed {
    logic              pflag;
    logic [CW_D-1:0]   pper;
    logic [CW_D-1:0]   ptgt;
    logic [CW_D-1:0]   pstep;
    logic [DIVW_D-1:0] pdiv;
    logic [CW_D-1:0]   per;
    logic [CW_D-1:0]   duty;
    logic [CW_D-1:0]   tgt;
    logic [CW_D-1:0]   step;
    logic [DIVW_D-1:0] div;
    logic [DIVW_D-1:0] divcnt;
    logic              ramping;
  } ch_state_t;

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Round-robin picker for the shared update engine.
// Ports:
//   req   - one request bit per channel
//   ptr   - channel with highest priority this round
//   grant - first requesting channel at or after ptr (wrapping)
//   any   - at least one request present
module pwm_rr_arbiter #(
  parameter int NCH = 8,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [CHW-1:0] grant,
  output logic           any
);

  int k;

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    grant = '0;
    any   = |req;
    k     = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NCH) k = k - NCH;
      if (req[k]) grant = CHW'(k);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Period/duty sequencer for the PWM counter bank.
// Software writes land in a per-channel pending set; a single shared engine
// (IDLE -> LOAD -> UPDATE) applies them, or advances a duty ramp, only when
// the channel's counter wraps, so outputs never change mid-period.
// Ports:
//   CLK, RST_N             - clock, async active-low reset
//   cfg_valid/cfg_ready    - config write handshake
//   cfg_ch/period/target/step/div - write payload (step 0 = jump)
//   wrap                   - per-channel period-boundary pulse
//   done_clr               - write-1-to-clear for done
//   period_out, duty_out   - active values, channel i at [i*CW +: CW]
//   busy                   - update pending or ramp running
//   done                   - sticky, ramp reached target
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int NCH  = NCH_D,
  parameter int CW   = CW_D,
  parameter int DIVW = DIVW_D
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_ch,
  input  logic [CW-1:0]       cfg_period,
  input  logic [CW-1:0]       cfg_target,
  input  logic [CW-1:0]       cfg_step,
  input  logic [DIVW-1:0]     cfg_div,
  input  logic [NCH-1:0]      wrap,
  input  logic [NCH-1:0]      done_clr,
  output logic [NCH*CW-1:0]   period_out,
  output logic [NCH*CW-1:0]   duty_out,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      done
);

  localparam int CHW = $clog2(NCH);

  // pending set
  logic [NCH-1:0][CW-1:0]   pper, ptgt, pstep;
  logic [NCH-1:0][DIVW-1:0] pdiv;
  logic [NCH-1:0]           pflag;
  // active set
  logic [NCH-1:0][CW-1:0]   per, duty, tgt, step;
  logic [NCH-1:0][DIVW-1:0] div, divcnt;
  logic [NCH-1:0]           ramping;
  logic [NCH-1:0]           wrap_pend;

  upd_state_t     state;
  logic [CHW-1:0] grant, rr, arb_idx;
  logic           arb_any;
  ch_state_t      snap;

  logic           accept;
  logic [NCH-1:0] wrap_pend_nxt, pflag_nxt, done_nxt;

  // update results for the granted channel
  logic [CW-1:0]   u_per, u_duty, u_tgt, u_step, diff;
  logic [DIVW-1:0] u_div, u_divcnt;
  logic            u_ramping, u_done_clr, u_done_set, reach;

  assign period_out = per;
  assign duty_out   = duty;
  assign busy       = pflag | ramping;

  // A channel in LOAD/UPDATE is blocked so its snapshot cannot go stale.
  assign cfg_ready = ~pflag[cfg_ch] &&
                     !(((state == ST_LOAD) || (state == ST_UPDATE)) && (grant == cfg_ch));
  assign accept    = cfg_valid && cfg_ready;

  pwm_rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req   (wrap_pend),
    .ptr   (rr),
    .grant (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pper  <= '0;
      ptgt  <= '0;
      pstep <= '0;
      pdiv  <= '0;
    end else if (accept) begin
      pper[cfg_ch]  <= cfg_period;
      ptgt[cfg_ch]  <= (cfg_target > cfg_period) ? cfg_period : cfg_target;
      pstep[cfg_ch] <= cfg_step;
      pdiv[cfg_ch]  <= cfg_div;
    end
  end

  always_comb begin
    // a wrap landing in the LOAD cycle survives the clear
    wrap_pend_nxt = wrap_pend;
    if (state == ST_LOAD) wrap_pend_nxt[grant] = 1'b0;
    wrap_pend_nxt = wrap_pend_nxt | wrap;

    pflag_nxt = pflag;
    if (state == ST_UPDATE) pflag_nxt[grant] = 1'b0;
    if (accept) pflag_nxt[cfg_ch] = 1'b1;

    // set beats software clear
    done_nxt = done & ~done_clr;
    if (state == ST_UPDATE) begin
      if (u_done_clr) done_nxt[grant] = 1'b0;
      if (u_done_set) done_nxt[grant] = 1'b1;
    end
  end

  always_comb begin
    u_per      = snap.per;
    u_duty     = snap.duty;
    u_tgt      = snap.tgt;
    u_step     = snap.step;
    u_div      = snap.div;
    u_divcnt   = snap.divcnt;
    u_ramping  = snap.ramping;
    u_done_clr = 1'b0;
    u_done_set = 1'b0;
    diff       = '0;
    reach      = 1'b0;
    if (snap.pflag) begin
      u_per      = snap.pper;
      u_tgt      = snap.ptgt;
      u_step     = snap.pstep;
      u_div      = snap.pdiv;
      u_divcnt   = '0;
      u_done_clr = 1'b1;
      if (snap.pstep == '0) begin
        u_duty     = snap.ptgt;
        u_ramping  = 1'b0;
        u_done_set = 1'b1;
      end else begin
        // ramp starts next tick; duty holds this period
        u_ramping  = (snap.duty != snap.ptgt);
        u_done_set = (snap.duty == snap.ptgt);
      end
    end else if (snap.ramping) begin
      if (snap.divcnt == snap.div) begin
        u_divcnt = '0;
        // distance first, so the step saturates at tgt without wrapping
        if (snap.duty < snap.tgt) begin
          diff   = snap.tgt - snap.duty;
          reach  = (diff <= snap.step);
          u_duty = reach ? snap.tgt : snap.duty + snap.step;
        end else begin
          diff   = snap.duty - snap.tgt;
          reach  = (diff <= snap.step);
          u_duty = reach ? snap.tgt : snap.duty - snap.step;
        end
        if (reach) begin
          u_ramping  = 1'b0;
          u_done_set = 1'b1;
        end
      end else begin
        u_divcnt = snap.divcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr        <= '0;
      wrap_pend <= '0;
      pflag     <= '0;
      done      <= '0;
      per       <= '0;
      duty      <= '0;
      tgt       <= '0;
      step      <= '0;
      div       <= '0;
      divcnt    <= '0;
      ramping   <= '0;
      snap      <= '0;
    end else begin
      wrap_pend <= wrap_pend_nxt;
      pflag     <= pflag_nxt;
      done      <= done_nxt;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant <= arb_idx;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          snap.pflag   <= pflag[grant];
          snap.pper    <= pper[grant];
          snap.ptgt    <= ptgt[grant];
          snap.pstep   <= pstep[grant];
          snap.pdiv    <= pdiv[grant];
          snap.per     <= per[grant];
          snap.duty    <= duty[grant];
          snap.tgt     <= tgt[grant];
          snap.step    <= step[grant];
          snap.div     <= div[grant];
          snap.divcnt  <= divcnt[grant];
          snap.ramping <= ramping[grant];
          state        <= ST_UPDATE;
        end
        ST_UPDATE: begin
          per[grant]     <= u_per;
          duty[grant]    <= u_duty;
          tgt[grant]     <= u_tgt;
          step[grant]    <= u_step;
          div[grant]     <= u_div;
          divcnt[grant]  <= u_divcnt;
          ramping[grant] <= u_ramping;
          rr             <= (grant == CHW'(NCH - 1)) ? '0 : grant + 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios plus randomized rounds scored
// against a per-channel behavioural model of the sequencing rules.
module tb_pwm_ramp_ctrl;

  localparam int NCH  = 8;
  localparam int CW   = 28;
  localparam int DIVW = 8;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [2:0]          cfg_ch = '0;
  logic [CW-1:0]       cfg_period = '0;
  logic [CW-1:0]       cfg_target = '0;
  logic [CW-1:0]       cfg_step = '0;
  logic [DIVW-1:0]     cfg_div = '0;
  logic [NCH-1:0]      wrap = '0;
  logic [NCH-1:0]      done_clr = '0;
  logic [NCH*CW-1:0]   period_out;
  logic [NCH*CW-1:0]   duty_out;
  logic [NCH-1:0]      busy;
  logic [NCH-1:0]      done;

  always #5 CLK = ~CLK;

  pwm_ramp_ctrl #(.NCH(NCH), .CW(CW), .DIVW(DIVW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_target(cfg_target), .cfg_step(cfg_step),
    .cfg_div(cfg_div), .wrap(wrap), .done_clr(done_clr),
    .period_out(period_out), .duty_out(duty_out), .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [CW-1:0] per_of(input int i);
    return period_out[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] duty_of(input int i);
    return duty_out[i*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int ch, input longint per, input longint tgt,
                    input longint stp, input longint dv, output bit ok);
    logic [63:0] v;
    cfg_ch = 3'(ch);
    v = per; cfg_period = v[CW-1:0];
    v = tgt; cfg_target = v[CW-1:0];
    v = stp; cfg_step   = v[CW-1:0];
    v = dv;  cfg_div    = v[DIVW-1:0];
    cfg_valid = 1'b1;
    #1;
    ok = cfg_ready;
    tick();
    cfg_valid = 1'b0;
  endtask

  // one wrap pulse, then enough time for a full 8-channel service burst
  task automatic svc(input logic [NCH-1:0] mask);
    wrap = mask;
    tick();
    wrap = '0;
    repeat (27) tick();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
  endtask

  // ---------------- behavioural model ----------------
  longint m_per[NCH], m_duty[NCH], m_tgt[NCH], m_step[NCH], m_div[NCH], m_cnt[NCH];
  bit     m_ramp[NCH], m_done[NCH];
  longint p_per[NCH], p_tgt[NCH], p_step[NCH], p_div[NCH];
  bit     p_flag[NCH];

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_per[i] = 0; m_duty[i] = 0; m_tgt[i] = 0; m_step[i] = 0; m_div[i] = 0; m_cnt[i] = 0;
      m_ramp[i] = 0; m_done[i] = 0;
      p_per[i] = 0; p_tgt[i] = 0; p_step[i] = 0; p_div[i] = 0; p_flag[i] = 0;
    end
  endtask

  task automatic m_accept(input int ch, input longint per, input longint tgt,
                          input longint stp, input longint dv);
    p_per[ch]  = per;
    p_tgt[ch]  = (tgt > per) ? per : tgt;
    p_step[ch] = stp;
    p_div[ch]  = dv;
    p_flag[ch] = 1;
  endtask

  task automatic m_service(input int i);
    if (p_flag[i]) begin
      m_per[i] = p_per[i]; m_tgt[i] = p_tgt[i]; m_step[i] = p_step[i]; m_div[i] = p_div[i];
      m_cnt[i] = 0; p_flag[i] = 0; m_done[i] = 0;
      if (m_step[i] == 0) begin
        m_duty[i] = m_tgt[i]; m_ramp[i] = 0; m_done[i] = 1;
      end else begin
        m_ramp[i] = (m_duty[i] != m_tgt[i]);
        if (!m_ramp[i]) m_done[i] = 1;
      end
    end else if (m_ramp[i]) begin
      if (m_cnt[i] == m_div[i]) begin
        m_cnt[i] = 0;
        if (m_duty[i] < m_tgt[i]) begin
          m_duty[i] = m_duty[i] + m_step[i];
          if (m_duty[i] > m_tgt[i]) m_duty[i] = m_tgt[i];
        end else begin
          m_duty[i] = m_duty[i] - m_step[i];
          if (m_duty[i] < m_tgt[i]) m_duty[i] = m_tgt[i];
        end
        if (m_duty[i] == m_tgt[i]) begin
          m_ramp[i] = 0; m_done[i] = 1;
        end
      end else begin
        m_cnt[i]++;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  bit ok;
  int upd_at[NCH];
  longint rup[9] = '{0, 0, 3, 3, 6, 6, 9, 9, 10};
  longint rdn[3] = '{30, 10, 5};

  task automatic burst(input int base, input string tag);
    for (int i = 0; i < NCH; i++) begin
      wr(i, 200, base + i, 0, 0, ok);
      upd_at[i] = 0;
    end
    wrap = '1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      wrap = '0;
      for (int i = 0; i < NCH; i++)
        if (upd_at[i] == 0 && duty_of(i) == CW'(base + i)) upd_at[i] = k;
    end
    chk({tag, "_ch0_seen"}, 64'(upd_at[0] > 0), 1);
    for (int i = 1; i < NCH; i++)
      chk($sformatf("%s_gap%0d", tag, i), 64'(upd_at[i] - upd_at[i-1]), 3);
    chk({tag, "_within25"}, 64'(upd_at[NCH-1] <= 25 && upd_at[NCH-1] > 0), 1);
  endtask

  initial begin
    logic [NCH-1:0] mask, clr, eb, ed;
    int ch;
    longint rp, rt, rs, rd;

    // reset state
    repeat (3) tick();
    #1;
    chk("rst_period", 64'(period_out), 0);
    chk("rst_duty", 64'(duty_out), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_ready", 64'(cfg_ready), 1);
    RST_N = 1'b1;
    tick();

    // jump on ch0, visible three cycles after the wrap cycle
    wr(0, 100, 40, 0, 0, ok);
    chk("jump_acc", 64'(ok), 1);
    chk("jump_busy_pend", 64'(busy[0]), 1);
    wrap[0] = 1'b1;
    tick();
    wrap = '0;
    repeat (3) tick();
    chk("jump_per", 64'(per_of(0)), 100);
    chk("jump_duty", 64'(duty_of(0)), 40);
    chk("jump_done", 64'(done[0]), 1);
    chk("jump_busy", 64'(busy[0]), 0);

    // done set wins over a simultaneous clear
    wr(0, 100, 20, 0, 0, ok);
    done_clr[0] = 1'b1;
    wrap[0] = 1'b1;
    tick();
    wrap = '0;
    repeat (3) tick();
    done_clr = '0;
    chk("setwin_duty", 64'(duty_of(0)), 20);
    chk("setwin_done", 64'(done[0]), 1);

    // ramp up ch1
    wr(1, 100, 10, 3, 1, ok);
    for (int k = 0; k < 9; k++) begin
      svc(8'h02);
      chk($sformatf("rup_duty%0d", k), 64'(duty_of(1)), 64'(rup[k]));
      chk($sformatf("rup_done%0d", k), 64'(done[1]), 64'(k == 8));
    end

    // ramp down with clamp on ch2
    wr(2, 50, 80, 0, 0, ok);
    svc(8'h04);
    chk("clamp_duty", 64'(duty_of(2)), 50);
    chk("clamp_done", 64'(done[2]), 1);
    wr(2, 50, 5, 20, 0, ok);
    svc(8'h04);
    chk("rdn_hold", 64'(duty_of(2)), 50);
    chk("rdn_done_clr", 64'(done[2]), 0);
    for (int k = 0; k < 3; k++) begin
      svc(8'h04);
      chk($sformatf("rdn_duty%0d", k), 64'(duty_of(2)), 64'(rdn[k]));
    end
    chk("rdn_done", 64'(done[2]), 1);
    chk("rdn_busy", 64'(busy[2]), 0);

    // back-pressure on ch3
    wr(3, 100, 7, 0, 0, ok);
    chk("bp_first", 64'(ok), 1);
    wr(3, 100, 9, 0, 0, ok);
    chk("bp_second", 64'(ok), 0);
    cfg_ch = 3'd3;
    wrap[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      wrap = '0;
      chk($sformatf("bp_ready%0d", k), 64'(cfg_ready), 64'(k == 4));
    end
    chk("bp_duty", 64'(duty_of(3)), 7);
    // no pending: ch3 is blocked only while it is being serviced
    wrap[3] = 1'b1;
    tick();
    wrap = '0;
    tick();
    cfg_target = 28'd9; cfg_step = '0; cfg_valid = 1'b1;
    #1;
    chk("bp_load_rdy", 64'(cfg_ready), 0);
    tick();
    chk("bp_upd_rdy", 64'(cfg_ready), 0);
    tick();
    cfg_valid = 1'b0;
    #1;
    chk("bp_idle_rdy", 64'(cfg_ready), 1);
    chk("bp_no_acc", 64'(busy[3]), 0);

    // contention from a clean rr pointer, twice
    do_reset();
    burst(10, "cont1");
    burst(20, "cont2");

    // reset in the middle of a ramp update
    do_reset();
    wr(1, 100, 50, 5, 0, ok);
    svc(8'h02);
    svc(8'h02);
    chk("mid_pre", 64'(duty_of(1)), 5);
    wrap[1] = 1'b1;
    tick();
    wrap = '0;
    tick();
    tick();
    RST_N = 1'b0;
    #1;
    chk("mid_per", 64'(period_out), 0);
    chk("mid_duty", 64'(duty_out), 0);
    chk("mid_busy", 64'(busy), 0);
    chk("mid_done", 64'(done), 0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("mid_ready", 64'(cfg_ready), 1);
    repeat (12) tick();
    chk("mid_idle_duty", 64'(duty_out), 0);
    chk("mid_idle_busy", 64'(busy), 0);

    // randomized rounds against the model
    m_reset();
    for (int r = 0; r < 40; r++) begin
      for (int w = 0; w < 2; w++) begin
        ch = $urandom_range(0, NCH - 1);
        rp = $urandom_range(10, 300);
        rt = $urandom_range(0, 350);
        rs = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
        rd = $urandom_range(0, 2);
        wr(ch, rp, rt, rs, rd, ok);
        chk($sformatf("r%0d_ready", r), 64'(ok), 64'(!p_flag[ch]));
        if (ok) m_accept(ch, rp, rt, rs, rd);
      end
      if ($urandom_range(0, 3) == 0) begin
        clr = NCH'($urandom);
        done_clr = clr;
        tick();
        done_clr = '0;
        for (int i = 0; i < NCH; i++) if (clr[i]) m_done[i] = 0;
      end
      mask = NCH'($urandom_range(0, 255));
      svc(mask);
      for (int i = 0; i < NCH; i++) if (mask[i]) m_service(i);
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("r%0d_per%0d", r, i), 64'(per_of(i)), 64'(m_per[i]));
        chk($sformatf("r%0d_duty%0d", r, i), 64'(duty_of(i)), 64'(m_duty[i]));
        eb[i] = p_flag[i] | m_ramp[i];
        ed[i] = m_done[i];
      end
      chk($sformatf("r%0d_busy", r), 64'(busy), 64'(eb));
      chk($sformatf("r%0d_done", r), 64'(done), 64'(ed));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
